// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// One shared BCD decoder, per-slot dark gap, double-buffered frames committed at frame wrap.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GAP_CYCLES  = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n,
  output logic                    frame_tick
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CntW-1:0] CntLast      = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] CntDriveLast = CntW'(REFRESH_DIV - GAP_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast      = IdxW'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {
    StDrive,
    StGap
  } state_e;

  state_e                         state_q;
  logic [CntW-1:0]                cnt_q;
  logic [IdxW-1:0]                idx_q;

  logic [NUM_DIGITS-1:0][3:0]     active_val_q;
  logic [NUM_DIGITS-1:0]          active_dp_q;
  logic [NUM_DIGITS-1:0][3:0]     shadow_val_q;
  logic [NUM_DIGITS-1:0]          shadow_dp_q;
  logic                           pending_q;
  logic                           pending_d;

  logic [3:0]                     bcd_q;
  logic [NUM_DIGITS-1:0]          an_n_q;
  logic                           dp_n_q;
  logic                           frame_tick_q;
  logic                           load_ready_q;

  logic                           slot_end;
  logic                           frame_wrap;
  logic                           accept;
  logic                           lz_run;
  logic [NUM_DIGITS-1:0]          blank_mask;
  logic [NUM_DIGITS-1:0]          digit_sel;

  assign slot_end   = (cnt_q == CntLast);
  assign frame_wrap = slot_end && (idx_q == IdxLast);
  assign accept     = load_valid && load_ready_q;

  // Leading-zero run walks down from the top digit; digit 0 is always shown.
  always_comb begin
    blank_mask = '0;
    lz_run     = blank_lz;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      lz_run        = lz_run && (active_val_q[i] == 4'h0) && !active_dp_q[i];
      blank_mask[i] = lz_run;
    end
  end

  always_comb begin
    digit_sel        = '0;
    digit_sel[idx_q] = 1'b1;
  end

  // A load can only be accepted while nothing is pending, so it never races the commit.
  always_comb begin
    pending_d = pending_q;
    if (frame_wrap) begin
      pending_d = 1'b0;
    end
    if (accept) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StDrive;
      cnt_q        <= '0;
      idx_q        <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      bcd_q        <= 4'h0;
      an_n_q       <= '1;
      dp_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
      load_ready_q <= 1'b0;
    end else begin
      cnt_q <= slot_end ? '0 : cnt_q + 1'b1;

      case (state_q)
        StDrive: begin
          if (cnt_q == CntDriveLast) begin
            state_q <= StGap;
          end
        end
        StGap: begin
          if (slot_end) begin
            state_q <= StDrive;
            idx_q   <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
          end
        end
        default: state_q <= StDrive;
      endcase

      if (state_q == StDrive) begin
        an_n_q <= blank_mask[idx_q] ? '1 : ~digit_sel;
        bcd_q  <= active_val_q[idx_q];
        dp_n_q <= ~active_dp_q[idx_q];
      end else begin
        an_n_q <= '1;
        dp_n_q <= 1'b1;
      end

      frame_tick_q <= frame_wrap;

      if (frame_wrap && pending_q) begin
        active_val_q <= shadow_val_q;
        active_dp_q  <= shadow_dp_q;
      end
      if (accept) begin
        shadow_val_q <= value_in;
        shadow_dp_q  <= dp_in;
      end
      pending_q    <= pending_d;
      load_ready_q <= ~pending_d;
    end
  end

  assign bcd_out    = bcd_q;
  assign an_n       = an_n_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = frame_tick_q;
  assign load_ready = load_ready_q;

endmodule
